// File: rtl/sbox_layer_serial_pkg.sv
`default_nettype none
// sbox_layer_serial_pkg: state encoding, reset S-box tables and nibble lookup helper.
// Rev 1.0
package sbox_layer_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Nibble i of each table holds the image of i (nibble 0 at the LSB).
  localparam logic [63:0] PRESENT_SBOX     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] PRESENT_SBOX_INV = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] tbl_lookup(input logic [63:0] tbl, input logic [3:0] idx);
    return tbl[{idx, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// sbox_lane: one combinational 4-bit S-box lookup, forward or inverse table.
// Rev 1.0
module sbox_lane
  import sbox_layer_serial_pkg::*;
(
  input  logic [3:0]  nib,
  input  logic        inv,
  input  logic [63:0] fwd_tbl,
  input  logic [63:0] inv_tbl,
  output logic [3:0]  sub
);

  assign sub = inv ? tbl_lookup(inv_tbl, nib) : tbl_lookup(fwd_tbl, nib);

endmodule
`default_nettype wire

// File: rtl/sbox_layer_serial.sv
`default_nettype none
// sbox_layer_serial: serial S-box layer, LANES nibbles per cycle, programmable table.
// Rev 1.0
module sbox_layer_serial
  import sbox_layer_serial_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              tbl_we,
  input  logic [3:0]        tbl_addr,
  input  logic [3:0]        tbl_data,
  output logic              busy,
  output logic              tbl_err
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int GRP_W = 4 * LANES;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIB - LANES);
  localparam logic [CNT_W-1:0]  CNT_STEP = CNT_W'(LANES);
  localparam logic [DATA_W-1:0] GRP_MASK = (DATA_W'(1) << GRP_W) - DATA_W'(1);

  if ((LANES < 1) || ((DATA_W % (4 * LANES)) != 0)) begin : g_param_check
    $error("sbox_layer_serial: DATA_W must be a multiple of 4*LANES");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              inv_sel_q, inv_sel_d;
  logic [63:0]       fwd_tbl_q, fwd_tbl_d;
  logic [63:0]       inv_tbl_q, inv_tbl_d;
  logic              tbl_err_q, tbl_err_d;

  logic [CNT_W+1:0]  grp_sh;
  logic [GRP_W-1:0]  grp_old;
  logic [GRP_W-1:0]  grp_new;

  assign grp_sh  = {cnt_q, 2'b00};
  assign grp_old = data_q[grp_sh +: GRP_W];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .nib     (grp_old[4*l +: 4]),
      .inv     (inv_sel_q),
      .fwd_tbl (fwd_tbl_q),
      .inv_tbl (inv_tbl_q),
      .sub     (grp_new[4*l +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    inv_sel_d = inv_sel_q;
    fwd_tbl_d = fwd_tbl_q;
    inv_tbl_d = inv_tbl_q;
    tbl_err_d = tbl_err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A table write takes priority; the pending word is accepted on a later cycle.
        in_ready = !tbl_we;
        if (tbl_we) begin
          fwd_tbl_d[{tbl_addr, 2'b00} +: 4] = tbl_data;
          inv_tbl_d[{tbl_data, 2'b00} +: 4] = tbl_addr;
        end else if (in_valid) begin
          data_d    = in_data;
          inv_sel_d = in_inv;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        data_d = (data_q & ~(GRP_MASK << grp_sh)) | (DATA_W'(grp_new) << grp_sh);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tbl_we && (state_q != S_IDLE)) tbl_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      inv_sel_q <= 1'b0;
      fwd_tbl_q <= PRESENT_SBOX;
      inv_tbl_q <= PRESENT_SBOX_INV;
      tbl_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      inv_sel_q <= inv_sel_d;
      fwd_tbl_q <= fwd_tbl_d;
      inv_tbl_q <= inv_tbl_d;
      tbl_err_q <= tbl_err_d;
    end
  end

  assign out_data = data_q;
  assign busy     = (state_q != S_IDLE);
  assign tbl_err  = tbl_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_layer_serial.sv
`default_nettype none
// tb_sbox_layer_serial: scoreboard bench for the serial S-box layer (LANES=1 and LANES=4).
// Rev 1.0
module tb_sbox_layer_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic        tbl_we, busy, tbl_err;
  logic [3:0]  tbl_addr, tbl_data;

  logic        in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [63:0] in_data4, out_data4;
  logic        tbl_we4, busy4, tbl_err4;
  logic [3:0]  tbl_addr4, tbl_data4;

  sbox_layer_serial #(.DATA_W(64), .LANES(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .busy(busy), .tbl_err(tbl_err)
  );

  sbox_layer_serial #(.DATA_W(64), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_inv(in_inv4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .tbl_we(tbl_we4), .tbl_addr(tbl_addr4), .tbl_data(tbl_data4), .busy(busy4), .tbl_err(tbl_err4)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] exp_q[$];
  string       name_q[$];
  logic [63:0] exp4_q[$];

  logic [3:0] fwd_m[16];
  logic [3:0] inv_m[16];

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic load_present();
    logic [3:0] f[16] = '{4'hC,4'h5,4'h6,4'hB,4'h9,4'h0,4'hA,4'hD,4'h3,4'hE,4'hF,4'h8,4'h4,4'h7,4'h1,4'h2};
    for (int i = 0; i < 16; i++) begin
      fwd_m[i] = f[i];
      inv_m[f[i]] = 4'(i);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] w, input logic inv);
    logic [63:0] r;
    logic [3:0]  n;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      n = w[4*i +: 4];
      r[4*i +: 4] = inv ? inv_m[n] : fwd_m[n];
    end
    return r;
  endfunction

  // Scoreboard monitors: pop one expectation per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual=%h expected=none", out_data);
      end else begin
        check64(name_q.pop_front(), out_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output4 actual=%h expected=none", out_data4);
      end else begin
        check64("lanes4_fwd", out_data4, exp4_q.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] w, input logic inv, input bit push,
                      input logic [63:0] exp, input string nm);
    bit hs = 0;
    if (push) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    in_data = w; in_inv = inv; in_valid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    hs_cyc = cyc;
    checks++;
    if (!hs) begin
      failures++;
      $display("FAIL %s_handshake actual=timeout required=accept", nm);
    end
  endtask

  task automatic wait_out_lat(input int exp_lat, input string nm);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s actual=timeout required=%0d", nm, exp_lat);
    end else begin
      check64(nm, 64'(cyc - hs_cyc + 1), 64'(exp_lat));
    end
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int k = 0; k < 300 && !idle; k++) begin
      @(negedge clk);
      idle = !busy && !out_valid;
    end
    if (!idle) begin
      checks++; failures++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [3:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    fwd_m[a] = d;
    inv_m[d] = a;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] w, f;
    bit seen;
    rst_n = 1'b0;
    in_valid = 0; in_inv = 0; in_data = '0; out_ready = 1'b1;
    tbl_we = 0; tbl_addr = '0; tbl_data = '0;
    in_valid4 = 0; in_inv4 = 0; in_data4 = '0; out_ready4 = 1'b1;
    tbl_we4 = 0; tbl_addr4 = '0; tbl_data4 = '0;
    load_present();

    repeat (3) @(posedge clk);
    #1;
    check64("rst_out_valid", 64'(out_valid), 64'd0);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_tbl_err", 64'(tbl_err), 64'd0);
    check64("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check64("idle_in_ready", 64'(in_ready), 64'd1);

    send(64'h0123456789ABCDEF, 1'b0, 1, 64'hC56B90AD3EF84712, "fwd_present");
    wait_out_lat(17, "latency_lanes1");
    wait_idle();
    send(64'hC56B90AD3EF84712, 1'b1, 1, 64'h0123456789ABCDEF, "inv_present");
    wait_idle();

    for (int i = 0; i < 100; i++) begin
      w = {$urandom, $urandom};
      f = model(w, 1'b0);
      send(w, 1'b0, 1, f, "rt_fwd");
      wait_idle();
      send(f, 1'b1, 1, w, "rt_inv");
      wait_idle();
    end

    // Backpressure: result held in DONE while the consumer stalls.
    out_ready = 1'b0;
    send(64'hA5A5A5A5A5A5A5A5, 1'b0, 1, 64'hF0F0F0F0F0F0F0F0, "bp_result");
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check64("bp_out_valid_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 10; k++) begin
      check64("bp_stable_data", out_data, 64'hF0F0F0F0F0F0F0F0);
      check64("bp_in_ready", 64'(in_ready), 64'd0);
      check64("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check64("bp_release_busy", 64'(busy), 64'd0);
    check64("bp_release_out_valid", 64'(out_valid), 64'd0);
    check64("bp_release_in_ready", 64'(in_ready), 64'd1);

    for (int x = 0; x < 16; x++) tbl_write(4'(x), 4'(x) ^ 4'hF);
    send(64'h0, 1'b0, 1, 64'hFFFFFFFFFFFFFFFF, "tbl_prog_fwd");
    wait_idle();
    send(64'hFFFFFFFFFFFFFFFF, 1'b1, 1, 64'h0, "tbl_prog_inv");
    wait_idle();

    // Reset during RUN discards the word and restores the PRESENT table.
    send(64'h0123456789ABCDEF, 1'b0, 0, 64'h0, "rst_mid_run");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check64("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check64("rst_mid_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_present();
    @(posedge clk); #1;
    send(64'h0123456789ABCDEF, 1'b0, 1, 64'hC56B90AD3EF84712, "fwd_after_reset");
    wait_idle();

    send(64'h0123456789ABCDEF, 1'b0, 1, 64'hC56B90AD3EF84712, "fwd_with_busy_write");
    repeat (3) @(posedge clk);
    #1;
    tbl_we = 1'b1; tbl_addr = 4'h0; tbl_data = 4'h0;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    @(negedge clk);
    check64("tbl_err_set", 64'(tbl_err), 64'd1);
    wait_idle();
    send(64'h0123456789ABCDEF, 1'b0, 1, 64'hC56B90AD3EF84712, "fwd_repeat");
    wait_idle();

    // Write wins over a simultaneous word; the word is taken next cycle and sees the new table.
    tbl_write(4'h1, 4'hC);
    exp_q.push_back(64'h5555555555555555);
    name_q.push_back("write_first_result");
    tbl_we = 1'b1; tbl_addr = 4'h0; tbl_data = 4'h5;
    in_valid = 1'b1; in_data = 64'h0; in_inv = 1'b0;
    @(negedge clk);
    check64("write_blocks_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    tbl_we = 1'b0;
    fwd_m[0] = 4'h5; inv_m[5] = 4'h0;
    @(negedge clk);
    check64("accept_after_write", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check64("accepted_busy", 64'(busy), 64'd1);
    wait_idle();
    check64("tbl_err_sticky", 64'(tbl_err), 64'd1);

    // LANES=4 instance: N=4 run cycles.
    exp4_q.push_back(64'hC56B90AD3EF84712);
    in_data4 = 64'h0123456789ABCDEF; in_inv4 = 1'b0; in_valid4 = 1'b1;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = in_ready4;
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    hs_cyc = cyc;
    check64("lanes4_handshake", 64'(seen), 64'd1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid4;
    end
    check64("latency_lanes4", seen ? 64'(cyc - hs_cyc + 1) : 64'hDEAD, 64'd5);
    repeat (3) @(posedge clk);
    #1;
    check64("lanes4_idle", 64'(busy4), 64'd0);

    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check64("scoreboard4_drained", 64'(exp4_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
